// File: rtl/mode_select_pkg.sv
// Shared constants and types for the coin-to-mode selector.
// Mode encodings are one-hot; MODE_NONE means no mode selected.
package mode_select_pkg;

  localparam logic [3:0] MODE_NONE = 4'b0000;
  localparam logic [3:0] MODE_1    = 4'b0001;
  localparam logic [3:0] MODE_2    = 4'b0010;
  localparam logic [3:0] MODE_3    = 4'b0100;
  localparam logic [3:0] MODE_4    = 4'b1000;

  localparam logic [2:0] COIN_MIN  = 3'd1;
  localparam logic [2:0] COIN_MAX  = 3'd4;

  // What the mode register does on the next edge, in priority order.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_CLEAR = 2'd1,
    ACT_LOAD  = 2'd2
  } mode_action_e;

endpackage

// File: rtl/mode_select_coin_decoder.sv
// Coin code to one-hot mode decode; purely combinational, latency 0.
// No backpressure; codes outside COIN_MIN..COIN_MAX decode to MODE_NONE.
module coin_decoder
  import mode_select_pkg::*;
(
  input  logic [2:0] coin,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = MODE_NONE;
    case (coin)
      3'd1:    onehot = MODE_1;
      3'd2:    onehot = MODE_2;
      3'd3:    onehot = MODE_3;
      3'd4:    onehot = MODE_4;
      default: onehot = MODE_NONE;
    endcase
  end

endmodule

// File: rtl/mode_select.sv
// Registered coin-to-mode selector; latency 1 clk, Mode is a flop output.
// No backpressure; isRunning freezes Mode, which beats Enable.
module mode_select
  import mode_select_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] Coin,
  input  logic       Enable,
  input  logic       isRunning,
  output logic [3:0] Mode
);

  logic [3:0]   decoded;
  logic [3:0]   mode_q;
  logic [3:0]   mode_nxt;
  mode_action_e action;

  coin_decoder u_coin_decoder (
    .coin   (Coin),
    .onehot (decoded)
  );

  always_comb begin
    action   = ACT_LOAD;
    mode_nxt = mode_q;
    if (isRunning) begin
      action = ACT_HOLD;
    end else if (!Enable) begin
      action = ACT_CLEAR;
    end
    case (action)
      ACT_HOLD:  mode_nxt = mode_q;
      ACT_CLEAR: mode_nxt = MODE_NONE;
      ACT_LOAD:  mode_nxt = decoded;
      default:   mode_nxt = MODE_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_NONE;
    end else begin
      mode_q <= mode_nxt;
    end
  end

  assign Mode = mode_q;

endmodule

// File: tb/tb_mode_select.sv
// Randomised and directed checks of mode_select against a behavioural model.
module tb_mode_select;

  logic       clk;
  logic       rst_n;
  logic [2:0] Coin;
  logic       Enable;
  logic       isRunning;
  logic [3:0] Mode;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_mode;

  mode_select dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Coin      (Coin),
    .Enable    (Enable),
    .isRunning (isRunning),
    .Mode      (Mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference: coin n in 1..4 selects bit n-1, anything else selects nothing.
  function automatic logic [3:0] model_decode(input int c);
    logic [3:0] r;
    r = 4'b0000;
    if (c >= 1 && c <= 4) r[c-1] = 1'b1;
    return r;
  endfunction

  task automatic step(input string tag, input int c, input bit en, input bit run);
    int ones;
    @(negedge clk);
    Coin      = c[2:0];
    Enable    = en;
    isRunning = run;
    @(posedge clk);
    if (!run) exp_mode = en ? model_decode(c) : 4'b0000;
    #1;
    check_val(tag, Mode, exp_mode);
    ones = $countones(Mode);
    check_val("onehot", {3'b000, ones <= 1}, 4'b0001);
  endtask

  initial begin
    rst_n     = 1'b0;
    Coin      = 3'd0;
    Enable    = 1'b0;
    isRunning = 1'b0;
    exp_mode  = 4'b0000;

    #3;
    check_val("reset_async", Mode, 4'b0000);
    #4;
    rst_n = 1'b1;

    step("idle_after_reset", 0, 1'b0, 1'b0);
    step("lock_from_reset", 1, 1'b0, 1'b1);

    step("select_1", 1, 1'b1, 1'b0);
    step("select_2", 2, 1'b1, 1'b0);
    step("select_3", 3, 1'b1, 1'b0);
    step("select_4", 4, 1'b1, 1'b0);

    step("invalid_0", 0, 1'b1, 1'b0);
    step("valid_again", 2, 1'b1, 1'b0);
    step("invalid_5", 5, 1'b1, 1'b0);
    step("invalid_6", 6, 1'b1, 1'b0);
    step("invalid_7", 7, 1'b1, 1'b0);

    step("freeze_setup", 3, 1'b1, 1'b0);
    step("freeze_en1", 4, 1'b1, 1'b1);
    step("freeze_en0", 4, 1'b0, 1'b1);
    step("freeze_en1b", 4, 1'b1, 1'b1);
    step("unlock_disable", 4, 1'b0, 1'b0);

    step("run_setup", 4, 1'b1, 1'b0);
    step("run_hold", 1, 1'b1, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_val("reset_midrun", Mode, 4'b0000);
    exp_mode = 4'b0000;
    #1 rst_n = 1'b1;
    step("hold_after_reset", 2, 1'b1, 1'b1);

    for (int i = 0; i < 300; i++) begin
      step("random", int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
